// File: rtl/autocorr_pkg.sv
// autocorr_pkg: shared types and sizing helpers for autocorr_stream (AUTOCORR_SYMMETRIC_EN selects symmetric beat count)
package autocorr_pkg;
  typedef enum logic {ACCUM, DRAIN} state_t;
  function automatic int acc_w(input int data_w, input int win_len);
    return 2 * data_w + $clog2(win_len);
  endfunction
  function automatic int lag_w(input int lags);
    return $clog2(lags) + 1;
  endfunction
  function automatic int beat_cnt(input int lags);
`ifdef AUTOCORR_SYMMETRIC_EN
    return 2 * lags - 1;
`else
    return lags;
`endif
  endfunction
endpackage

// File: rtl/autocorr_lag_mac.sv
// autocorr_lag_mac: signed multiply-accumulate for one correlation lag
module autocorr_lag_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  assign prod = a * b;
  assign acc = acc_q;
  // clear wins over accumulate; product is sign-extended into the accumulator
  always_comb acc_d = clr ? '0 : en ? acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod} : acc_q;
  // accumulator register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/autocorr_stream.sv
// autocorr_stream: streaming windowed autocorrelator, one lag per output beat (AUTOCORR_SYMMETRIC_EN adds negative lags)
module autocorr_stream
  import autocorr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LAGS = 4,
  parameter int WIN_LEN = 16,
  localparam int ACC_W = acc_w(DATA_W, WIN_LEN),
  localparam int LAG_W = lag_w(LAGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [LAG_W-1:0]  out_lag,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     busy
);
  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam int IW = $clog2(LAGS);
  localparam logic signed [LAG_W-1:0] FIRST_LAG = LAG_W'(LAGS - beat_cnt(LAGS));
  localparam logic signed [LAG_W-1:0] LAST_LAG = LAG_W'(LAGS - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [DATA_W-1:0] dl_q [LAGS-1];
  logic signed [DATA_W-1:0] dl_d [LAGS-1];
  logic signed [DATA_W-1:0] tap [LAGS];
  logic signed [ACC_W-1:0] acc [LAGS];
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic signed [LAG_W-1:0] out_lag_q, out_lag_d;
  logic [IW-1:0] idx;
  logic accept, done, clr;
  assign in_ready = state_q == ACCUM;
  assign accept = in_valid && in_ready && !clear;
  assign done = state_q == DRAIN && out_ready && out_last_q;
  assign clr = clear || done;
  assign busy = state_q == DRAIN || cnt_q != '0;
  assign out_valid = out_valid_q;
  assign out_lag = out_lag_q;
  assign out_last = out_last_q;
  assign idx = IW'(out_lag_q[LAG_W-1] ? -out_lag_q : out_lag_q);
  assign out_data = out_valid_q ? acc[idx] : '0;
  // tap k is the current sample delayed by k accepted samples
  always_comb begin
    tap[0] = in_data;
    for (int i = 1; i < LAGS; i++) tap[i] = dl_q[i-1];
  end
  for (genvar k = 0; k < LAGS; k++) begin : g_mac
    autocorr_lag_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .clk(clk), .rst_n(rst_n), .clr(clr), .en(accept), .a(in_data), .b(tap[k]), .acc(acc[k])
    );
  end
  // accumulate until the window fills, then step through the lag beats
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dl_d = dl_q;
    out_valid_d = out_valid_q;
    out_lag_d = out_lag_q;
    out_last_d = out_last_q;
    if (clr) begin
      state_d = ACCUM;
      cnt_d = '0;
      dl_d = '{default: '0};
      out_valid_d = 1'b0;
      out_lag_d = '0;
      out_last_d = 1'b0;
    end else if (accept) begin
      dl_d[0] = in_data;
      for (int i = 1; i < LAGS - 1; i++) dl_d[i] = dl_q[i-1];
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIN_LEN - 1)) begin
        state_d = DRAIN;
        out_valid_d = 1'b1;
        out_lag_d = FIRST_LAG;
      end
    end else if (state_q == DRAIN && out_ready) begin
      out_lag_d = out_lag_q + LAG_W'(1);
      out_last_d = out_lag_d == LAST_LAG;
    end
  end
  // state, counter, delay line and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q <= '0;
      dl_q <= '{default: '0};
      out_valid_q <= 1'b0;
      out_lag_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dl_q <= dl_d;
      out_valid_q <= out_valid_d;
      out_lag_q <= out_lag_d;
      out_last_q <= out_last_d;
    end
endmodule

// File: tb/tb_autocorr_stream.sv
// tb_autocorr_stream: randomized and directed checks of autocorr_stream against a window-level reference model
module tb_autocorr_stream;
  import autocorr_pkg::*;
  localparam int DW = 8;
  localparam int L = 4;
  localparam int W = 4;
  localparam int AW = acc_w(DW, W);
  localparam int AW16 = acc_w(DW, 16);
  localparam int LW = lag_w(L);
`ifdef AUTOCORR_SYMMETRIC_EN
  localparam int NB = 2 * L - 1;
  int t1_lag [NB] = '{-3, -2, -1, 0, 1, 2, 3};
  int t1_val [NB] = '{4, 11, 20, 30, 20, 11, 4};
  int t2_val [NB] = '{212992, 229376, 245760, 262144, 245760, 229376, 212992};
`else
  localparam int NB = L;
  int t1_lag [NB] = '{0, 1, 2, 3};
  int t1_val [NB] = '{30, 20, 11, 4};
  int t2_val [NB] = '{262144, 245760, 229376, 212992};
`endif
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy;
  logic signed [LW-1:0] out_lag;
  logic signed [AW-1:0] out_data;
  logic v16 = 1'b0;
  logic signed [DW-1:0] d16 = '0;
  logic rdy16, ov16, last16, busy16;
  logic signed [LW-1:0] lag16;
  logic signed [AW16-1:0] od16;
  typedef struct {int lag; longint val; bit last;} beat_t;
  beat_t exq[$];
  beat_t got[$];
  int win[$];
  int n_cmp = 0, n_bad = 0;

  autocorr_stream #(.DATA_W(DW), .LAGS(L), .WIN_LEN(W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_lag(out_lag),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );
  autocorr_stream #(.DATA_W(DW), .LAGS(L), .WIN_LEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(v16), .in_ready(rdy16),
    .in_data(d16), .out_valid(ov16), .out_ready(1'b1), .out_lag(lag16),
    .out_data(od16), .out_last(last16), .busy(busy16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // expected beats for a completed window, straight from R[k] = sum x[n]*x[n-k]
  function automatic void push_window();
    longint r [L];
    for (int k = 0; k < L; k++) begin
      r[k] = 0;
      for (int n = k; n < W; n++) r[k] += longint'(win[n] * win[n-k]);
    end
`ifdef AUTOCORR_SYMMETRIC_EN
    for (int g = -(L - 1); g < L; g++) exq.push_back('{g, r[g < 0 ? -g : g], g == L - 1});
`else
    for (int g = 0; g < L; g++) exq.push_back('{g, r[g], g == L - 1});
`endif
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exq.delete();
      win.delete();
    end else if (clear) begin
      exq.delete();
      win.delete();
    end else if (exq.size() != 0) begin
      if (out_ready) void'(exq.pop_front());
    end else if (in_valid) begin
      win.push_back(int'(in_data));
      if (win.size() == W) begin
        push_window();
        win.delete();
      end
    end

  always @(negedge clk) begin
    chk("in_ready", in_ready, exq.size() == 0);
    chk("out_valid", out_valid, exq.size() != 0);
    chk("busy", busy, exq.size() != 0 || win.size() != 0);
    if (exq.size() != 0) begin
      chk("out_lag", out_lag, exq[0].lag);
      chk("out_data", out_data, exq[0].val);
      chk("out_last", out_last, exq[0].last);
      if (out_ready && !clear && rst_n) got.push_back('{int'(out_lag), longint'(out_data), out_last});
    end else chk("out_data_idle", out_data, 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int gap);
    bit ok;
    int b;
    in_valid = 1'b1;
    in_data = DW'(x);
    b = 0;
    do begin
      ok = in_ready;
      step();
      b++;
    end while (!ok && b < 200);
    if (!ok) chk("send_timeout", 1, 0);
    in_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic wait_idle();
    int b;
    b = 0;
    while ((busy || !in_ready) && b < 200) begin
      step();
      b++;
    end
    if (b >= 200) chk("idle_timeout", 1, 0);
  endtask

  task automatic check_t1(input string nm);
    chk({nm, "_beats"}, got.size(), NB);
    for (int i = 0; i < NB && i < got.size(); i++) begin
      chk({nm, "_lag"}, got[i].lag, t1_lag[i]);
      chk({nm, "_val"}, got[i].val, t1_val[i]);
      chk({nm, "_last"}, got[i].last, i == NB - 1);
    end
  endtask

  task automatic run_t1(input int gap);
    got.delete();
    for (int i = 1; i <= 4; i++) send(i, i == 4 ? 0 : gap);
  endtask

  initial begin
    int st, b;
    repeat (2) step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    run_t1(0);
    wait_idle();
    check_t1("t1");
    chk("t1_in_ready_after", in_ready, 1);
    got.delete();
    for (int i = 0; i < 16; i++) begin
      v16 = 1'b1;
      d16 = -8'sd128;
      step();
    end
    v16 = 1'b0;
    b = 0;
    while (!ov16 && b < 50) begin
      step();
      b++;
    end
    for (int i = 0; i < NB; i++) begin
      chk("t2_valid", ov16, 1);
      chk("t2_val", od16, t2_val[i]);
      chk("t2_last", last16, i == NB - 1);
      step();
    end
    chk("t2_done", ov16, 0);
    chk("t2_in_ready", rdy16, 1);
    run_t1(2);
    st = 0;
    b = 0;
    while ((busy || !in_ready) && b < 100) begin
      if (out_valid && out_lag == 1 && st < 3) begin
        out_ready = 1'b0;
        st++;
      end else out_ready = 1'b1;
      step();
      b++;
    end
    out_ready = 1'b1;
    if (b >= 100) chk("t3_timeout", 1, 0);
    check_t1("t3");
    send(5, 0);
    send(5, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t4_busy", busy, 0);
    run_t1(0);
    wait_idle();
    check_t1("t4");
    run_t1(0);
    b = 0;
    while (!(out_valid && out_lag == 2) && b < 50) begin
      step();
      b++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_in_ready", in_ready, 1);
    run_t1(0);
    wait_idle();
    check_t1("t5");
    for (int c = 0; c < 400; c++) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_data = DW'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      clear = $urandom_range(0, 60) == 0;
      step();
    end
    in_valid = 1'b0;
    clear = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
